snake_ctrl: RTL and testbench
=============================

# snake_ctrl

Upstream control stage for `snake_field`. It turns raw push-button inputs into the `start`, `step`, `snake_dir` and `seed` stimulus that `snake_field` consumes. Internally it synchronises and debounces the buttons, latches the requested direction, paces the game with a programmable step timer, and runs an IDLE/PLAYING/PAUSED state machine. Its outputs connect directly to the same-named `snake_field` inputs.

## Interface
- `STEP_DIV`, default 24'd5_000_000: clock cycles per game step; legal range ≥ 2.
- `DEB_CYCLES`, default 20'd500_000: consecutive stable cycles needed to accept a button level change; legal range ≥ 1.
- `SEED_MAX`, default 100: number of field cells; seed wraps at this value.
- `SBITS`, default `$clog2(SEED_MAX)`: seed width.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `btn_up`, `btn_right`, `btn_down`, `btn_left`  in  1 each  raw, asynchronous, active-high direction buttons.
- `btn_start`  in  1  raw pause/resume button.
- `btn_new`  in  1  raw new-game button.
- `start`  out  1  one-cycle new-game pulse to `snake_field`.
- `step`  out  1  one-cycle advance pulse to `snake_field`.
- `snake_dir`  out  2  requested direction: 0 up, 1 right, 2 down, 3 left.
- `seed`  out  SBITS  apple-placement seed, always < SEED_MAX.
- `playing`  out  1  high in PLAYING.
- `paused`  out  1  high in PAUSED.

## Operation
- **Input conditioning.** Each of the 6 buttons goes through a 2-flop synchroniser and then a debouncer.
  - Each debouncer has a counter. It clears whenever the synchronised level equals the debounced level; otherwise it increments.
  - When the counter reaches DEB_CYCLES, the debounced level takes the synchronised level and the counter clears.
  - A press event is a 0→1 change of the debounced level. It lasts one cycle.
- **Direction latch.**
  - In PLAYING, a direction press event loads `snake_dir`.
  - If several direction events occur in the same cycle, priority is up > right > down > left.
  - Direction events are ignored in IDLE and PAUSED.
  - Reversal filtering is not done here; `snake_field` performs it.
- **Seed.**
  - Free-running counter in all states: 0, 1, …, SEED_MAX-1, then wraps to 0.
  - `seed` shows the counter value directly. Randomness comes from human press timing.
- **FSM.** States are IDLE, PLAYING, PAUSED.
  - IDLE: a `btn_start` or `btn_new` event produces a `start` pulse, sets `snake_dir`←1, clears the step timer, and moves to PLAYING.
  - PLAYING: the step timer counts 0..STEP_DIV-1. When it wraps, `step` pulses.
  - PLAYING: a `btn_start` event moves to PAUSED with the timer frozen at its current value.
  - PAUSED: a `btn_start` event moves back to PLAYING, and the timer resumes from its frozen value.
  - Any state: a `btn_new` event produces a `start` pulse, sets `snake_dir`←1, clears the timer, and moves to PLAYING. This has priority over a `btn_start` event in the same cycle.
- **Pulse exclusivity.** `start` and `step` are never high in the same cycle. The timer clears on the start cycle, so the first step comes STEP_DIV cycles after `start`.
- **Reset.** While `rst` is low:
  - All state and outputs clear immediately: state=IDLE, `start`=0, `step`=0, `snake_dir`=2'd1, `seed`=0, `playing`=0, `paused`=0.
  - Debounced levels, debounce counters, synchronisers and the step timer are all 0.
  - A reset in the middle of a debounce or step interval discards any pending event.

## Timing
- All outputs are registered.
- **Button to `start` latency.** Raw button held high from before edge E0 → debounced level rises at edge E0+DEB_CYCLES+1 → `start` is high for one cycle after edge E0+DEB_CYCLES+2.
- **Direction latency.** `snake_dir` updates on the same edge a `start` would assert.
- **Step cadence.** Exactly STEP_DIV cycles between consecutive `step` pulses while continuously PLAYING.
- **Across a pause.** Elapsed PLAYING cycles between steps total STEP_DIV.
- **Bounce rejection.** A glitch shorter than DEB_CYCLES cycles produces no event.
- **Release.** Button release produces no event, but it also must be debounced for DEB_CYCLES cycles before the next press is accepted.

## Test plan
All scenarios use STEP_DIV=8, DEB_CYCLES=4, SEED_MAX=100.
- **Reset then start.** Release `rst`, raise `btn_start` → `start` high for exactly 1 cycle, 7 edges after first sampling; `playing`=1; `snake_dir`=1; first `step` 8 cycles later; then a `step` every 8 cycles.
- **Bounce.** `btn_up` toggles with 3-cycle high pulses → no `snake_dir` change. `btn_up` held 10 cycles → `snake_dir`=0.
- **Simultaneous directions.** `btn_down` and `btn_left` rise together in PLAYING → `snake_dir`=2.
- **Pause.** Pause 3 cycles after a `step`, hold paused 50 cycles, resume → next `step` 5 PLAYING cycles after resume. Direction presses while paused leave `snake_dir` unchanged.
- **New game.** `btn_new` while PAUSED with `snake_dir`=3 → `start` pulse, `snake_dir`=1, `playing`=1, `paused`=0, no `step` in the same cycle.
- **Seed and mid-run reset.** `seed` reaches 99 then 0 on the next cycle. Assert `rst` mid-interval → outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/snake_ctrl_if.sv
// Button inputs and game-control outputs between the button panel and snake_ctrl.
interface snake_ctrl_if #(
    parameter int SBITS = 7
);
    logic             btn_up;
    logic             btn_right;
    logic             btn_down;
    logic             btn_left;
    logic             btn_start;
    logic             btn_new;
    logic             start;
    logic             step;
    logic [1:0]       snake_dir;
    logic [SBITS-1:0] seed;
    logic             playing;
    logic             paused;

    modport master (
        output btn_up, btn_right, btn_down, btn_left, btn_start, btn_new,
        input  start, step, snake_dir, seed, playing, paused
    );

    modport slave (
        input  btn_up, btn_right, btn_down, btn_left, btn_start, btn_new,
        output start, step, snake_dir, seed, playing, paused
    );
endinterface

// File: rtl/snake_ctrl.sv
// Game control for snake_field: button conditioning, direction latch,
// free-running seed, step pacing and IDLE/PLAYING/PAUSED sequencing.

// One button: 2-flop synchroniser, debouncer, rising-edge press detect.
module snake_ctrl_deb #(
    parameter logic [19:0] DEB_CYCLES = 20'd500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_press
);
    logic [1:0]  r_sync;
    logic [19:0] r_cnt;
    logic        r_deb;
    logic        r_deb_d;

    // Debounced level flips on the DEB_CYCLES-th consecutive differing sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_deb   <= 1'b0;
            r_deb_d <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_raw};
            r_deb_d <= r_deb;
            if (r_sync[1] == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == DEB_CYCLES - 20'd1) begin
                r_deb <= r_sync[1];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 20'd1;
            end
        end
    end

    assign o_press = r_deb & ~r_deb_d;
endmodule

module snake_ctrl #(
    parameter logic [23:0] STEP_DIV   = 24'd5_000_000,
    parameter logic [19:0] DEB_CYCLES = 20'd500_000,
    parameter int          SEED_MAX   = 100,
    parameter int          SBITS      = $clog2(SEED_MAX)
) (
    input  logic         clk,
    input  logic         rst,
    snake_ctrl_if.slave  bus
);
    localparam int B_UP = 0, B_RIGHT = 1, B_DOWN = 2, B_LEFT = 3, B_START = 4, B_NEW = 5;
    localparam int NBTN = 6;

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE} state_t;

    logic [NBTN-1:0] w_raw;
    logic [NBTN-1:0] w_press;

    state_t           r_state, w_state_nxt;
    logic [23:0]      r_timer, w_timer_nxt;
    logic [1:0]       r_dir, w_dir_nxt;
    logic             r_start, w_start_nxt;
    logic             r_step, w_step_nxt;
    logic             r_playing, r_paused;
    logic [SBITS-1:0] r_seed;

    assign w_raw = {bus.btn_new, bus.btn_start, bus.btn_left,
                    bus.btn_down, bus.btn_right, bus.btn_up};

    genvar g;
    generate
        for (g = 0; g < NBTN; g++) begin : g_btn
            snake_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
                .clk     (clk),
                .rst     (rst),
                .i_raw   (w_raw[g]),
                .o_press (w_press[g])
            );
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next state, timer, direction and pulses; new-game overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_dir_nxt   = r_dir;
        w_start_nxt = 1'b0;
        w_step_nxt  = 1'b0;
        if (w_press[B_NEW] || (r_state == S_IDLE && w_press[B_START])) begin
            w_state_nxt = S_PLAY;
            w_start_nxt = 1'b1;
            w_dir_nxt   = 2'd1;
            w_timer_nxt = '0;
        end else begin
            case (r_state)
                S_PLAY: begin
                    // The pausing cycle still counts as a playing cycle.
                    if (r_timer == STEP_DIV - 24'd1) begin
                        w_timer_nxt = '0;
                        w_step_nxt  = 1'b1;
                    end else begin
                        w_timer_nxt = r_timer + 24'd1;
                    end
                    if (w_press[B_START]) w_state_nxt = S_PAUSE;
                    if      (w_press[B_UP])    w_dir_nxt = 2'd0;
                    else if (w_press[B_RIGHT]) w_dir_nxt = 2'd1;
                    else if (w_press[B_DOWN])  w_dir_nxt = 2'd2;
                    else if (w_press[B_LEFT])  w_dir_nxt = 2'd3;
                end
                S_PAUSE: begin
                    if (w_press[B_START]) w_state_nxt = S_PLAY;
                end
                default: ;
            endcase
        end
    end

    // Registered outputs and timer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timer   <= '0;
            r_dir     <= 2'd1;
            r_start   <= 1'b0;
            r_step    <= 1'b0;
            r_playing <= 1'b0;
            r_paused  <= 1'b0;
        end else begin
            r_timer   <= w_timer_nxt;
            r_dir     <= w_dir_nxt;
            r_start   <= w_start_nxt;
            r_step    <= w_step_nxt;
            r_playing <= (w_state_nxt == S_PLAY);
            r_paused  <= (w_state_nxt == S_PAUSE);
        end
    end

    // Free-running seed, sampled implicitly by human press timing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                               r_seed <= '0;
        else if (r_seed == SBITS'(SEED_MAX - 1)) r_seed <= '0;
        else                                    r_seed <= r_seed + 1'b1;
    end

    assign bus.start     = r_start;
    assign bus.step      = r_step;
    assign bus.snake_dir = r_dir;
    assign bus.seed      = r_seed;
    assign bus.playing   = r_playing;
    assign bus.paused    = r_paused;
endmodule

// File: tb/tb_snake_ctrl.sv
// Bench for snake_ctrl: directed scenarios plus random button activity,
// every cycle compared against a cycle-level behavioural model.
module tb_snake_ctrl;
    localparam logic [23:0] SD = 24'd8;
    localparam logic [19:0] DB = 20'd4;
    localparam int          SM = 100;
    localparam int          SB = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] btn = '0;   // up, right, down, left, start, new

    always #5 clk = ~clk;

    snake_ctrl_if #(.SBITS(SB)) bus();
    assign bus.btn_up    = btn[0];
    assign bus.btn_right = btn[1];
    assign bus.btn_down  = btn[2];
    assign bus.btn_left  = btn[3];
    assign bus.btn_start = btn[4];
    assign bus.btn_new   = btn[5];

    snake_ctrl #(.STEP_DIV(SD), .DEB_CYCLES(DB), .SEED_MAX(SM), .SBITS(SB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: game mode 0 idle / 1 playing / 2 paused, playing cycles since last step.
    int mode, elapsed, m_dir, m_seed;
    bit m_start, m_step;
    int s1 [6], s2 [6], lvl [6], lvl_d [6], run [6];
    int gap = 0, last_gap = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mode = 0; elapsed = 0; m_dir = 1; m_seed = 0; m_start = 0; m_step = 0;
        for (int b = 0; b < 6; b++) begin
            s1[b] = 0; s2[b] = 0; lvl[b] = 0; lvl_d[b] = 0; run[b] = 0;
        end
    endtask

    task automatic model_edge();
        bit ev [6];
        int old2;
        for (int b = 0; b < 6; b++) ev[b] = (lvl[b] == 1) && (lvl_d[b] == 0);
        m_start = 0;
        m_step  = 0;
        if (ev[5] || (mode == 0 && ev[4])) begin
            m_start = 1; m_dir = 1; elapsed = 0; mode = 1;
        end else if (mode == 1) begin
            elapsed++;
            if (elapsed == int'(SD)) begin m_step = 1; elapsed = 0; end
            if (ev[0])      m_dir = 0;
            else if (ev[1]) m_dir = 1;
            else if (ev[2]) m_dir = 2;
            else if (ev[3]) m_dir = 3;
            if (ev[4]) mode = 2;
        end else if (mode == 2 && ev[4]) begin
            mode = 1;
        end
        m_seed = (m_seed + 1) % SM;
        for (int b = 0; b < 6; b++) begin
            lvl_d[b] = lvl[b];
            old2  = s2[b];
            s2[b] = s1[b];
            s1[b] = int'(btn[b]);
            run[b] = (old2 != lvl[b]) ? run[b] + 1 : 0;
            if (run[b] == int'(DB)) begin lvl[b] = old2; run[b] = 0; end
        end
    endtask

    task automatic check_model();
        chk("m_start",   bus.start,     32'(m_start));
        chk("m_step",    bus.step,      32'(m_step));
        chk("m_dir",     bus.snake_dir, 32'(m_dir));
        chk("m_seed",    bus.seed,      32'(m_seed));
        chk("m_playing", bus.playing,   32'(mode == 1));
        chk("m_paused",  bus.paused,    32'(mode == 2));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_edge();
        @(negedge clk);
        check_model();
        if (bus.step === 1'b1) begin last_gap = gap; gap = 0; end
        if (bus.playing === 1'b1) gap++;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_start"},   bus.start,     0);
        chk({tag, "_step"},    bus.step,      0);
        chk({tag, "_dir"},     bus.snake_dir, 1);
        chk({tag, "_seed"},    bus.seed,      0);
        chk({tag, "_playing"}, bus.playing,   0);
        chk({tag, "_paused"},  bus.paused,    0);
    endtask

    initial begin
        int lat, found;
        int hold [6];
        model_reset();

        // Reset state.
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");

        // Reset then start.
        rst = 1'b1;
        btn[4] = 1'b1;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.start === 1'b1) begin lat = i; break; end
        end
        chk("start_latency", lat, 7);
        tick();
        chk("start_width", bus.start, 0);
        chk("start_playing", bus.playing, 1);
        chk("start_dir", bus.snake_dir, 1);
        btn[4] = 1'b0;
        lat = -1;
        for (int i = 2; i <= 20; i++) begin
            tick();
            if (bus.step === 1'b1) begin lat = i; break; end
        end
        chk("first_step", lat, 8);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.step === 1'b1) begin lat = i; break; end
        end
        chk("step_period", lat, 8);

        // Bounce rejection, then a clean press.
        repeat (4) begin
            btn[0] = 1'b1; ticks(3);
            btn[0] = 1'b0; ticks(3);
        end
        chk("bounce_dir", bus.snake_dir, 1);
        btn[0] = 1'b1; ticks(10);
        chk("up_dir", bus.snake_dir, 0);
        btn[0] = 1'b0; ticks(8);

        // Simultaneous down + left.
        btn[2] = 1'b1; btn[3] = 1'b1; ticks(10);
        chk("simul_dir", bus.snake_dir, 2);
        btn[2] = 1'b0; btn[3] = 1'b0; ticks(8);

        // Pause three playing cycles after a step.
        found = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.step === 1'b1) begin found = 1; break; end
        end
        chk("pause_sync_found", found, 1);
        ticks(4);
        btn[4] = 1'b1; ticks(10);
        btn[4] = 1'b0;
        chk("paused", bus.paused, 1);
        ticks(40);
        btn[1] = 1'b1; ticks(10);
        btn[1] = 1'b0; ticks(10);
        chk("paused_dir", bus.snake_dir, 2);
        btn[4] = 1'b1;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.playing === 1'b1) begin found = 1; break; end
        end
        chk("resume_found", found, 1);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.step === 1'b1) begin lat = i; break; end
        end
        chk("resume_step", lat, 5);
        chk("gap_across_pause", last_gap, 8);
        btn[4] = 1'b0; ticks(8);

        // New game from PAUSED with direction left.
        btn[3] = 1'b1; ticks(10);
        btn[3] = 1'b0;
        chk("left_dir", bus.snake_dir, 3);
        ticks(8);
        btn[4] = 1'b1; ticks(10);
        btn[4] = 1'b0;
        chk("paused2", bus.paused, 1);
        ticks(8);
        btn[5] = 1'b1;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.start === 1'b1) begin found = 1; break; end
        end
        chk("new_start", found, 1);
        chk("new_step", bus.step, 0);
        chk("new_dir", bus.snake_dir, 1);
        chk("new_playing", bus.playing, 1);
        chk("new_paused", bus.paused, 0);
        btn[5] = 1'b0; ticks(8);

        // Seed wrap.
        found = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.seed === SB'(99)) begin found = 1; break; end
            tick();
        end
        chk("seed_99_found", found, 1);
        tick();
        chk("seed_wrap", bus.seed, 0);

        // Random button activity.
        for (int b = 0; b < 6; b++) hold[b] = 0;
        repeat (1500) begin
            for (int b = 0; b < 6; b++) begin
                if (hold[b] == 0) begin
                    btn[b]  = 1'($urandom_range(0, 1));
                    hold[b] = $urandom_range(1, 12);
                end else begin
                    hold[b]--;
                end
            end
            tick();
        end
        btn = '0; ticks(8);

        // Mid-interval reset is immediate.
        btn[5] = 1'b1; ticks(12);
        btn[5] = 1'b0; ticks(3);
        #2 rst = 1'b0;
        #1 chk_reset_vals("midrst");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        ticks(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
